instr_packer: RTL and testbench
===============================

INSTR_PACKER -- requirements
Module: instr_packer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: field set present.
REQ-004 The block SHALL have port in_ready, output, 1 bit: field set accepted when in_valid and in_ready are both high at a clk edge.
REQ-005 The block SHALL have port fmt, input, 2 bits: 00 R-type, 01 I-type, 10 J-type, 11 illegal.
REQ-006 The block SHALL have field ports, all inputs: opcode 7 bits, rs1 5 bits, rs2 5 bits, rd 5 bits, shamt 5 bits, funct 6 bits, offset 16 bits, imme 26 bits.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_instr and out_addr hold valid data.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the sink pops a word when out_valid and out_ready are both high at a clk edge.
REQ-009 The block SHALL have port out_instr, output, 32 bits: the packed instruction word.
REQ-010 The block SHALL have port out_addr, output, 32 bits: the byte address of out_instr.
REQ-011 The block SHALL have ports base_load, input, 1 bit, and base_addr, input, 32 bits: load the address counter.
REQ-012 The block SHALL have port count, output, 16 bits: number of words popped since reset.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse for a rejected field set.

Function
REQ-014 The block SHALL pack R-type words as {opcode[5:0], rs1, rs2, rd, shamt, funct}.
REQ-015 The block SHALL pack I-type words as {opcode[5:0], rs1, rs2, offset}.
REQ-016 The block SHALL pack J-type words as {opcode[5:0], imme}.
REQ-017 The block SHALL ignore fields unused by the selected format.
REQ-018 The block SHALL store packed words in a 2-entry FIFO.
REQ-019 in_ready SHALL equal NOT full, so the block never accepts a word into a full FIFO, including when a pop occurs in the same cycle.
REQ-020 An accepted word SHALL appear on out_instr with out_valid high in the cycle after acceptance, giving 1-cycle latency when the FIFO is empty.
REQ-021 When the FIFO is non-empty and not full, a simultaneous push and pop SHALL leave the occupancy unchanged and preserve word order.
REQ-022 out_valid SHALL equal NOT empty.
REQ-023 out_instr SHALL show the head entry and SHALL hold stable while out_valid is high and out_ready is low.
REQ-024 out_addr SHALL be the address counter value; the counter SHALL increment by 4 on each pop and wrap from 0xFFFFFFFC to 0x00000000.
REQ-025 When base_load is high, the counter SHALL take base_addr at the next edge; base_load SHALL have priority over a same-cycle pop increment, and that pop is still counted in count.
REQ-026 count SHALL increment on each pop and saturate at 0xFFFF.
REQ-027 err SHALL be 0 unless raised under REQ-031.

Reset
REQ-028 While rst_n is low, the block SHALL empty the FIFO, clear the address counter to 0, clear count to 0, and hold err at 0.
REQ-029 Reset asserted mid-operation SHALL discard buffered words immediately, with out_valid low asynchronously.
REQ-030 After reset, in_ready SHALL be 1, out_valid SHALL be 0, and out_instr SHALL be 0.

Configuration
REQ-031 With macro INSTR_PACKER_CHECK_EN defined, an accepted field set with fmt==11 or opcode[6]==1 SHALL be consumed but not pushed, and err SHALL pulse high for one cycle after acceptance.
REQ-032 With INSTR_PACKER_CHECK_EN undefined, fmt==11 SHALL pack as J-type, opcode[6] SHALL be ignored, and err SHALL be tied to 0.

Verification
REQ-033 R-type with opcode=0, rs1=1, rs2=2, rd=3, shamt=0, funct=0x20 and out_ready=1 -> out_instr=0x00221820 and out_addr=0 one cycle after acceptance.
REQ-034 I-type with opcode=0x23, rs1=29, rs2=8, offset=0x0010, then J-type with opcode=0x02, imme=0x0000040, both with out_ready=1 -> 0x8FA80010 at address 0, then 0x08000040 at address 4.
REQ-035 out_ready=0 with three pushes attempted -> two accepted, in_ready=0, outputs stable; then out_ready=1 -> words drain in order at addresses 0 and 4, and in_ready returns high.
REQ-036 base_load=1 with base_addr=0xFFFFFFFC, then two pops -> out_addr=0xFFFFFFFC, then 0x00000000; count=2.
REQ-037 With INSTR_PACKER_CHECK_EN defined, fmt=11 accepted -> err=1 for one cycle, out_valid stays 0; rst_n pulsed low with 2 words buffered -> out_valid=0 immediately and count=0.

Source files
------------

// File: rtl/instr_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_packer_if
// Description : Field-set input handshake and packed-word output handshake
//               of the instruction packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_packer_if;
  // Field-set side
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] offset;
  logic [25:0] imme;
  // Packed-word side
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  // Packer view
  modport slave (
    input  in_valid, fmt, opcode, rs1, rs2, rd, shamt, funct, offset, imme,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );

  // Producer / sink view
  modport master (
    output in_valid, fmt, opcode, rs1, rs2, rd, shamt, funct, offset, imme,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );
endinterface
`default_nettype wire

// File: rtl/instr_packer.sv
`default_nettype none
// ============================================================================
// Module      : instr_packer
// Description : Packs R/I/J field sets into 32-bit words, buffers them in a
//               2-entry FIFO and tags each word with a byte address counter.
//               Optional macro INSTR_PACKER_CHECK_EN drops illegal field sets
//               (fmt==11 or opcode[6]==1) and pulses err.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_packer (
  input  wire logic        clk,
  input  wire logic        rst_n,
  instr_packer_if.slave    bus,
  input  wire logic        base_load,
  input  wire logic [31:0] base_addr,
  output logic      [15:0] count,
  output logic             err
);

  localparam logic [1:0]  FMT_R     = 2'b00;
  localparam logic [1:0]  FMT_I     = 2'b01;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic [31:0] mem_q [2];
  logic [31:0] mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  occ_q, occ_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;

  logic [31:0] packed_word;
  logic        drop;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;

  assign full  = (occ_q == 2'd2);
  assign empty = (occ_q == 2'd0);

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_instr = mem_q[rd_ptr_q];
  assign bus.out_addr  = addr_q;
  assign count         = count_q;
  assign err           = err_q;

  // Format selects the field layout; fmt==11 falls through to the J layout.
  always_comb begin
    packed_word = '0;
    case (bus.fmt)
      FMT_R:   packed_word = {bus.opcode[5:0], bus.rs1, bus.rs2, bus.rd,
                              bus.shamt, bus.funct};
      FMT_I:   packed_word = {bus.opcode[5:0], bus.rs1, bus.rs2, bus.offset};
      default: packed_word = {bus.opcode[5:0], bus.imme};
    endcase
  end

`ifdef INSTR_PACKER_CHECK_EN
  // Illegal field sets are consumed (handshake completes) but never stored.
  assign drop = (bus.fmt == 2'b11) || bus.opcode[6];
`else
  // opcode[6] carries no meaning when legality checking is off.
  logic unused_opcode_msb;
  assign unused_opcode_msb = bus.opcode[6];
  assign drop = 1'b0;
`endif

  assign accept = bus.in_valid & ~full;
  assign push   = accept & ~drop;
  assign pop    = ~empty & bus.out_ready;

  // Next-state for FIFO, address counter, pop counter and error pulse.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = accept & drop;

    if (push) begin
      mem_d[wr_ptr_q] = packed_word;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // A load wins over the pop increment; the pop still counts.
    if (base_load) begin
      addr_d = base_addr;
    end else if (pop) begin
      addr_d = addr_q + 32'd4;
    end
    if (pop && (count_q != COUNT_MAX)) begin
      count_d = count_q + 16'd1;
    end
  end

  // State registers; reset empties the FIFO and clears the head word to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_instr_packer
// Description : Self-checking bench for instr_packer: queue-based reference
//               model checked every cycle plus literal directed expectations.
//               Honours INSTR_PACKER_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        base_load;
  logic [31:0] base_addr;
  logic [15:0] count;
  logic        err;

  int checks   = 0;
  int failures = 0;

  instr_packer_if bus ();

  instr_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .base_load (base_load),
    .base_addr (base_addr),
    .count     (count),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference packing from field weights: bit position = sum of widths to the right.
  function automatic logic [31:0] ref_pack(input logic [1:0] f, input logic [6:0] op,
                                           input logic [4:0] s1, input logic [4:0] s2,
                                           input logic [4:0] d, input logic [4:0] sh,
                                           input logic [5:0] fn, input logic [15:0] ofs,
                                           input logic [25:0] im);
    logic [31:0] top;
    top = 32'(op % 64) * 32'h0400_0000;
    if (f == 2'd0)
      return top + 32'(s1) * 2097152 + 32'(s2) * 65536 + 32'(d) * 2048 + 32'(sh) * 64 + 32'(fn);
    else if (f == 2'd1)
      return top + 32'(s1) * 2097152 + 32'(s2) * 65536 + 32'(ofs);
    else
      return top + 32'(im);
  endfunction

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] m_addr;
  int          m_count;
  logic        m_err;

  // Compare on the falling edge, then advance the model by the coming rising edge.
  always @(negedge clk) begin
    bit acc, pop, bad;
    if (!rst_n) begin
      mq.delete();
      m_addr  = 32'd0;
      m_count = 0;
      m_err   = 1'b0;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_instr", bus.out_instr,      32'd0);
      chk("rst_out_addr",  bus.out_addr,       32'd0);
      chk("rst_count",     32'(count),         32'd0);
      chk("rst_err",       32'(err),           32'd0);
    end else begin
      chk("m_in_ready",  32'(bus.in_ready),  (mq.size() < 2) ? 32'd1 : 32'd0);
      chk("m_out_valid", 32'(bus.out_valid), (mq.size() > 0) ? 32'd1 : 32'd0);
      if (mq.size() > 0) chk("m_out_instr", bus.out_instr, mq[0]);
      chk("m_out_addr", bus.out_addr, m_addr);
      chk("m_count",    32'(count),   32'(m_count));
      chk("m_err",      32'(err),     32'(m_err));

      acc = bus.in_valid && (mq.size() < 2);
      pop = (mq.size() > 0) && bus.out_ready;
`ifdef INSTR_PACKER_CHECK_EN
      bad = (bus.fmt == 2'd3) || bus.opcode[6];
`else
      bad = 1'b0;
`endif
      m_err = acc && bad;
      if (pop) begin
        void'(mq.pop_front());
        if (m_count < 65535) m_count++;
      end
      if (base_load)  m_addr = base_addr;
      else if (pop)   m_addr = m_addr + 32'd4;
      if (acc && !bad)
        mq.push_back(ref_pack(bus.fmt, bus.opcode, bus.rs1, bus.rs2, bus.rd,
                              bus.shamt, bus.funct, bus.offset, bus.imme));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_r(input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn);
    bus.fmt = 2'b00; bus.opcode = op; bus.rs1 = s1; bus.rs2 = s2;
    bus.rd = d; bus.shamt = sh; bus.funct = fn;
  endtask

  task automatic set_i(input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [15:0] ofs);
    bus.fmt = 2'b01; bus.opcode = op; bus.rs1 = s1; bus.rs2 = s2; bus.offset = ofs;
  endtask

  task automatic set_j(input logic [6:0] op, input logic [25:0] im);
    bus.fmt = 2'b10; bus.opcode = op; bus.imme = im;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.fmt = '0; bus.opcode = '0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
    bus.shamt = '0; bus.funct = '0; bus.offset = '0; bus.imme = '0;
    base_load = 1'b0; base_addr = '0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // R-type, one-cycle latency
    set_r(7'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("r_valid", 32'(bus.out_valid), 32'd1);
    chk("r_word",  bus.out_instr, 32'h0022_1820);
    chk("r_addr",  bus.out_addr,  32'h0000_0000);
    tick();
    chk("r_count", 32'(count), 32'd1);
    chk("r_addr_after_pop", bus.out_addr, 32'h0000_0004);

    // I-type then J-type back to back
    do_reset();
    bus.out_ready = 1'b1;
    set_i(7'h23, 5'd29, 5'd8, 16'h0010);
    bus.in_valid = 1'b1;
    tick();
    set_j(7'h02, 26'h000_0040);
    chk("i_word", bus.out_instr, 32'h8FA8_0010);
    chk("i_addr", bus.out_addr,  32'h0000_0000);
    tick();
    bus.in_valid = 1'b0;
    chk("j_word", bus.out_instr, 32'h0800_0040);
    chk("j_addr", bus.out_addr,  32'h0000_0004);
    tick();
    chk("ij_count", 32'(count), 32'd2);
    chk("ij_empty", 32'(bus.out_valid), 32'd0);

    // Backpressure: three pushes, two accepted, then drain
    do_reset();
    bus.out_ready = 1'b0;
    set_r(7'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    bus.in_valid = 1'b1;
    tick();
    set_i(7'h23, 5'd29, 5'd8, 16'h0010);
    tick();
    set_j(7'h02, 26'h000_0040);
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head",       bus.out_instr,     32'h0022_1820);
    chk("bp_head_addr",  bus.out_addr,      32'h0000_0000);
    tick();
    chk("bp_still_full", 32'(bus.in_ready), 32'd0);
    chk("bp_stable",     bus.out_instr,     32'h0022_1820);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_second",      bus.out_instr,     32'h8FA8_0010);
    chk("bp_second_addr", bus.out_addr,      32'h0000_0004);
    chk("bp_ready_back",  32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    chk("bp_count",   32'(count),         32'd2);

    // Base load and address wrap
    do_reset();
    bus.out_ready = 1'b0;
    base_load = 1'b1; base_addr = 32'hFFFF_FFFC;
    set_j(7'h02, 26'h000_0040);
    bus.in_valid = 1'b1;
    tick();
    base_load = 1'b0;
    set_i(7'h23, 5'd29, 5'd8, 16'h0010);
    tick();
    bus.in_valid = 1'b0;
    chk("wrap_base", bus.out_addr, 32'hFFFF_FFFC);
    bus.out_ready = 1'b1;
    tick();
    chk("wrap_zero", bus.out_addr, 32'h0000_0000);
    tick();
    chk("wrap_count", 32'(count), 32'd2);
    // Load wins over a same-cycle pop, pop still counted
    set_r(7'h01, 5'd4, 5'd5, 5'd6, 5'd7, 6'h08);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    base_load = 1'b1; base_addr = 32'h0000_1000;
    tick();
    base_load = 1'b0;
    chk("load_prio_addr",  bus.out_addr, 32'h0000_1000);
    chk("load_prio_count", 32'(count),   32'd3);

    // Mixed pattern sweep, checked by the model every cycle
    for (int i = 0; i < 40; i++) begin
      bus.fmt       = 2'(i % 4);
      bus.opcode    = 7'(i * 13 + 5);
      bus.rs1       = 5'(i * 3);
      bus.rs2       = 5'(i * 7 + 1);
      bus.rd        = 5'(31 - i);
      bus.shamt     = 5'(i);
      bus.funct     = 6'(i * 5);
      bus.offset    = 16'(i * 16'h0123);
      bus.imme      = 26'(i * 26'h0012345);
      bus.in_valid  = (i % 3) != 2;
      bus.out_ready = (i % 5) < 3;
      base_load     = (i == 17);
      base_addr     = 32'h0000_0100;
      tick();
    end
    bus.in_valid = 1'b0; base_load = 1'b0; bus.out_ready = 1'b1;
    tick(); tick(); tick();

`ifdef INSTR_PACKER_CHECK_EN
    // Illegal format is consumed, not stored, and flagged for one cycle
    do_reset();
    bus.out_ready = 1'b1;
    set_j(7'h02, 26'h000_0040);
    bus.fmt = 2'b11;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("ill_err",   32'(err),           32'd1);
    chk("ill_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("ill_err_clear", 32'(err), 32'd0);
`else
    // fmt 11 packs as J and opcode[6] is ignored
    do_reset();
    bus.out_ready = 1'b0;
    set_j(7'h42, 26'h000_0040);
    bus.fmt = 2'b11;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("fmt3_word", bus.out_instr, 32'h0800_0040);
    chk("fmt3_err",  32'(err),      32'd0);
    bus.out_ready = 1'b1;
    tick();
`endif

    // Asynchronous reset with two words buffered
    do_reset();
    bus.out_ready = 1'b1;
    set_r(7'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    chk("ar_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("ar_pre_count", 32'(count),         32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_count", 32'(count),         32'd0);
    chk("ar_ready", 32'(bus.in_ready),  32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
